// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer
//   Layer-level controller for one convolution layer. The output channels are
//   processed in groups of OCH_GROUP. For each group the sequencer starts the
//   weight loader, waits for it, then starts the IFM module and waits for it.
//   The layer configuration is latched on acceptance and held until the next
//   accepted configuration.
//
//   Optional build macro: WGT_PREFETCH_EN
//     When defined, weights are double-buffered. The next group's weights are
//     requested while the current group computes. The extra output
//     wgt_buf_sel tells the IFM module which weight buffer to read.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   cfg_vld / cfg_rdy      layer config handshake (cfg_rdy only in IDLE)
//   cfg_ifm_w, cfg_ich,    layer config fields
//   cfg_och, cfg_stride,
//   cfg_is_conv3x3
//   ifm_w, ich, stride,    latched layer config to the IFM module
//   is_conv3x3
//   wgt_start, wgt_grp     weight-load request pulse and its group index
//   wgt_done               weight load complete pulse
//   ifm_start, ifm_done    IFM module start / done pulses
//   grp_idx                group currently computing
//   wgt_buf_sel            weight buffer read by the IFM group (WGT_PREFETCH_EN only)
//   busy                   high outside IDLE
//   layer_done             pulse after the last group
//   cfg_err                pulse when a config is rejected
//
// States
//   IDLE     | waiting for cfg_vld; cfg_rdy high
//   CHECK    | validate latched config, compute group count
//   LOAD_WGT | wgt_start pulse visible for current group
//   WAIT_WGT | waiting for wgt_done
//   RUN_IFM  | issue ifm_start for current group
//   WAIT_IFM | waiting for ifm_done; advance group or finish
//   DONE     | issue layer_done
module conv_layer_sequencer #(
  parameter int OCH_GROUP  = 16,
  parameter int MAX_GROUPS = 16,
  parameter int GRP_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_vld,
  output logic             cfg_rdy,
  input  logic [8:0]       cfg_ifm_w,
  input  logic [8:0]       cfg_ich,
  input  logic [8:0]       cfg_och,
  input  logic [1:0]       cfg_stride,
  input  logic             cfg_is_conv3x3,
  output logic [8:0]       ifm_w,
  output logic [8:0]       ich,
  output logic [1:0]       stride,
  output logic             is_conv3x3,
  output logic             wgt_start,
  output logic [GRP_W-1:0] wgt_grp,
  input  logic             wgt_done,
  output logic             ifm_start,
  input  logic             ifm_done,
  output logic [GRP_W-1:0] grp_idx,
  output logic             busy,
  output logic             layer_done,
`ifdef WGT_PREFETCH_EN
  output logic             wgt_buf_sel,
`endif
  output logic             cfg_err
);

  localparam int OCH_SH = $clog2(OCH_GROUP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LOAD_WGT,
    S_WAIT_WGT,
    S_RUN_IFM,
    S_WAIT_IFM,
    S_DONE
  } state_t;

  state_t           state;
  logic [8:0]       och;
  logic [GRP_W-1:0] grp;
  logic [9:0]       och_rnd;
  logic [5:0]       num_grp;
  logic             cfg_bad;
  logic             last_grp;
`ifdef WGT_PREFETCH_EN
  logic             pf_done;
`endif

  // Group count rounds up; 10-bit intermediate keeps och=511 from wrapping.
  assign och_rnd  = {1'b0, och} + 10'(OCH_GROUP - 1);
  assign num_grp  = 6'(och_rnd >> OCH_SH);
  assign cfg_bad  = (och == 9'd0) || (ich == 9'd0) || (ifm_w == 9'd0) ||
                    (stride == 2'd0) || (stride == 2'd3) ||
                    (num_grp > 6'(MAX_GROUPS));
  assign last_grp = (6'(grp) == (num_grp - 6'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      och        <= '0;
      ifm_w      <= '0;
      ich        <= '0;
      stride     <= '0;
      is_conv3x3 <= 1'b0;
      grp        <= '0;
      grp_idx    <= '0;
      wgt_grp    <= '0;
      wgt_start  <= 1'b0;
      ifm_start  <= 1'b0;
      layer_done <= 1'b0;
      cfg_err    <= 1'b0;
      busy       <= 1'b0;
      cfg_rdy    <= 1'b1;
`ifdef WGT_PREFETCH_EN
      pf_done     <= 1'b0;
      wgt_buf_sel <= 1'b0;
`endif
    end else begin
      wgt_start  <= 1'b0;
      ifm_start  <= 1'b0;
      layer_done <= 1'b0;
      cfg_err    <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cfg_vld) begin
            ifm_w      <= cfg_ifm_w;
            ich        <= cfg_ich;
            och        <= cfg_och;
            stride     <= cfg_stride;
            is_conv3x3 <= cfg_is_conv3x3;
            cfg_rdy    <= 1'b0;
            busy       <= 1'b1;
            state      <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (cfg_bad) begin
            cfg_err <= 1'b1;
            cfg_rdy <= 1'b1;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            // wgt_start is raised on entry so it is visible during LOAD_WGT.
            grp       <= '0;
            wgt_grp   <= '0;
            wgt_start <= 1'b1;
`ifdef WGT_PREFETCH_EN
            pf_done   <= 1'b0;
`endif
            state     <= S_LOAD_WGT;
          end
        end

        S_LOAD_WGT: state <= S_WAIT_WGT;

        S_WAIT_WGT: begin
          if (wgt_done) state <= S_RUN_IFM;
        end

        S_RUN_IFM: begin
          ifm_start <= 1'b1;
          grp_idx   <= grp;
`ifdef WGT_PREFETCH_EN
          // Buffer parity follows the group index: group 0 reads buffer 0.
          wgt_buf_sel <= grp[0];
          pf_done     <= 1'b0;
          if (!last_grp) begin
            wgt_start <= 1'b1;
            wgt_grp   <= grp + 1'b1;
          end
`endif
          state <= S_WAIT_IFM;
        end

        S_WAIT_IFM: begin
`ifdef WGT_PREFETCH_EN
          if (wgt_done) pf_done <= 1'b1;
`endif
          if (ifm_done) begin
            if (last_grp) begin
              state <= S_DONE;
            end else begin
              grp <= grp + 1'b1;
`ifdef WGT_PREFETCH_EN
              // Prefetched weights already loaded: skip straight to compute.
              pf_done <= 1'b0;
              if (pf_done || wgt_done) state <= S_RUN_IFM;
              else                     state <= S_WAIT_WGT;
`else
              wgt_grp   <= grp + 1'b1;
              wgt_start <= 1'b1;
              state     <= S_LOAD_WGT;
`endif
            end
          end
        end

        S_DONE: begin
          layer_done <= 1'b1;
          busy       <= 1'b0;
          cfg_rdy    <= 1'b1;
          state      <= S_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          cfg_rdy <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Testbench for conv_layer_sequencer: directed layers with a pulse scoreboard.
module tb_conv_layer_sequencer;

  logic       clk;
  logic       rst;
  logic       cfg_vld;
  logic       cfg_rdy;
  logic [8:0] cfg_ifm_w;
  logic [8:0] cfg_ich;
  logic [8:0] cfg_och;
  logic [1:0] cfg_stride;
  logic       cfg_is_conv3x3;
  logic [8:0] ifm_w;
  logic [8:0] ich;
  logic [1:0] stride;
  logic       is_conv3x3;
  logic       wgt_start;
  logic [3:0] wgt_grp;
  logic       wgt_done;
  logic       ifm_start;
  logic       ifm_done;
  logic [3:0] grp_idx;
  logic       busy;
  logic       layer_done;
  logic       cfg_err;
`ifdef WGT_PREFETCH_EN
  logic       wgt_buf_sel;
`endif

  conv_layer_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_vld        (cfg_vld),
    .cfg_rdy        (cfg_rdy),
    .cfg_ifm_w      (cfg_ifm_w),
    .cfg_ich        (cfg_ich),
    .cfg_och        (cfg_och),
    .cfg_stride     (cfg_stride),
    .cfg_is_conv3x3 (cfg_is_conv3x3),
    .ifm_w          (ifm_w),
    .ich            (ich),
    .stride         (stride),
    .is_conv3x3     (is_conv3x3),
    .wgt_start      (wgt_start),
    .wgt_grp        (wgt_grp),
    .wgt_done       (wgt_done),
    .ifm_start      (ifm_start),
    .ifm_done       (ifm_done),
    .grp_idx        (grp_idx),
    .busy           (busy),
    .layer_done     (layer_done),
`ifdef WGT_PREFETCH_EN
    .wgt_buf_sel    (wgt_buf_sel),
`endif
    .cfg_err        (cfg_err)
  );

  localparam int K_WGT = 0, K_IFM = 1, K_DONE = 2, K_ERR = 3;

  typedef struct {
    int kind;
    int grp;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input int kind, input int g, input int c);
    ev_t e;
    e.kind = kind;
    e.grp  = g;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic match_ev(input int kind, input int g);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      e.kind = -1;
      e.grp  = 0;
      e.cyc  = 0;
    end else begin
      e = exp_q.pop_front();
    end
    assert (e.kind == kind && e.grp == g && e.cyc == cyc) else begin
      errors++;
      $error("FAIL pulse observed kind=%0d grp=%0d cyc=%0d expected kind=%0d grp=%0d cyc=%0d",
             kind, g, cyc, e.kind, e.grp, e.cyc);
    end
  endtask

  // Pulse monitor; same-cycle pulses are matched in the order ifm, wgt, done, err.
  always @(negedge clk) begin
    if (ifm_start)  match_ev(K_IFM, int'(grp_idx));
    if (wgt_start)  match_ev(K_WGT, int'(wgt_grp));
    if (layer_done) match_ev(K_DONE, 0);
    if (cfg_err)    match_ev(K_ERR, 0);
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drive_done(input bit w, input bit i);
    wgt_done = w;
    ifm_done = i;
    @(negedge clk);
    wgt_done = 1'b0;
    ifm_done = 1'b0;
  endtask

  // Drives one config cycle; returns the cycle in which cfg_vld was driven.
  task automatic send_cfg(input int och_v, input int ich_v, input int w_v,
                          input int st_v, input bit k3, output int hs);
    cfg_och        = 9'(och_v);
    cfg_ich        = 9'(ich_v);
    cfg_ifm_w      = 9'(w_v);
    cfg_stride     = 2'(st_v);
    cfg_is_conv3x3 = k3;
    cfg_vld        = 1'b1;
    hs             = cyc;
    @(negedge clk);
    cfg_vld = 1'b0;
  endtask

  task automatic check_illegal(input string tag, input int och_v, input int ich_v,
                               input int w_v, input int st_v);
    int hs;
    push_ev(K_ERR, 0, cyc + 2);
    send_cfg(och_v, ich_v, w_v, st_v, 1'b0, hs);
    wait_cyc(hs + 3);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rdy"}, 32'(cfg_rdy), 32'd1);
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Serial flow: wgt_done 5 cycles after wgt_start, ifm_done 20 after ifm_start.
  // Stops after ifm_start of stop_grp when stop_grp < n.
  task automatic run_groups(input int n, input int stop_grp, input bit spur, input int t_w0);
    int t_w, t_i;
    t_w = t_w0;
    for (int g = 0; g < n; g++) begin
      t_i = t_w + 7;
      if (spur) begin
        wait_cyc(t_w + 2);
        drive_done(1'b0, 1'b1);
      end
      wait_cyc(t_w + 5);
      push_ev(K_IFM, g, t_i);
      drive_done(1'b1, spur);
      if (g == stop_grp) begin
        wait_cyc(t_i + 2);
        return;
      end
      wait_cyc(t_i + 1);
      chk("grp_idx", 32'(grp_idx), 32'(g));
      if (spur) begin
        wait_cyc(t_i + 3);
        drive_done(1'b1, 1'b0);
      end
      wait_cyc(t_i + 20);
      if (g == n - 1) begin
        push_ev(K_DONE, 0, t_i + 22);
      end else begin
        push_ev(K_WGT, g + 1, t_i + 21);
        t_w = t_i + 21;
      end
      drive_done(1'b0, 1'b1);
    end
    wait_cyc(t_i + 23);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_rdy", 32'(cfg_rdy), 32'd1);
    chk("end_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int hs;
    rst            = 1'b1;
    cfg_vld        = 1'b0;
    cfg_ifm_w      = '0;
    cfg_ich        = '0;
    cfg_och        = '0;
    cfg_stride     = '0;
    cfg_is_conv3x3 = 1'b0;
    wgt_done       = 1'b0;
    ifm_done       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 32'(cfg_rdy), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulses", 32'({wgt_start, ifm_start, layer_done, cfg_err}), 32'd0);
    chk("rst_ifm_w", 32'(ifm_w), 32'd0);
    chk("rst_grp_idx", 32'(grp_idx), 32'd0);
    rst = 1'b0;
    @(negedge clk);

`ifndef WGT_PREFETCH_EN
    // Single-group layer.
    push_ev(K_WGT, 0, cyc + 2);
    send_cfg(16, 16, 8, 1, 1'b1, hs);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_rdy", 32'(cfg_rdy), 32'd0);
    run_groups(1, 99, 1'b0, hs + 2);
    chk("t1_ifm_w", 32'(ifm_w), 32'd8);
    chk("t1_ich", 32'(ich), 32'd16);
    chk("t1_stride", 32'(stride), 32'd1);
    chk("t1_k3", 32'(is_conv3x3), 32'd1);

    // Three groups; a second cfg_vld while busy must be ignored.
    push_ev(K_WGT, 0, cyc + 2);
    send_cfg(40, 3, 12, 2, 1'b0, hs);
    cfg_ifm_w = 9'd99;
    cfg_vld   = 1'b1;
    @(negedge clk);
    cfg_vld = 1'b0;
    run_groups(3, 99, 1'b0, hs + 2);
    chk("t2_ifm_w", 32'(ifm_w), 32'd12);
    chk("t2_stride", 32'(stride), 32'd2);

    // Rejected configs.
    check_illegal("ill_stride3", 16, 16, 8, 3);
    check_illegal("ill_och0", 0, 16, 8, 1);
    check_illegal("ill_och300", 300, 16, 8, 1);

    // Spurious dones in the wrong wait state are ignored.
    push_ev(K_WGT, 0, cyc + 2);
    send_cfg(32, 8, 8, 1, 1'b1, hs);
    run_groups(2, 99, 1'b1, hs + 2);

    // Reset during group 1 of 3, then a fresh layer starts at group 0.
    push_ev(K_WGT, 0, cyc + 2);
    send_cfg(40, 8, 8, 1, 1'b1, hs);
    run_groups(3, 1, 1'b0, hs + 2);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rdy", 32'(cfg_rdy), 32'd1);
    chk("mid_rst_cfg", 32'({ifm_w, ich, stride}), 32'd0);
    chk("mid_rst_grp", 32'(grp_idx), 32'd0);
    rst = 1'b0;
    drive_done(1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("mid_rst_pending", 32'(exp_q.size()), 32'd0);
    push_ev(K_WGT, 0, cyc + 2);
    send_cfg(16, 4, 6, 1, 1'b0, hs);
    run_groups(1, 99, 1'b0, hs + 2);
`else
    // Prefetch: group 1 weights requested alongside group 0 ifm_start.
    push_ev(K_WGT, 0, cyc + 2);
    send_cfg(32, 16, 8, 1, 1'b1, hs);
    wait_cyc(hs + 5);
    push_ev(K_IFM, 0, hs + 7);
    push_ev(K_WGT, 1, hs + 7);
    drive_done(1'b1, 1'b0);
    wait_cyc(hs + 7);
    chk("pf_buf0", 32'(wgt_buf_sel), 32'd0);
    wait_cyc(hs + 9);
    drive_done(1'b1, 1'b0);
    wait_cyc(hs + 12);
    push_ev(K_IFM, 1, hs + 14);
    drive_done(1'b0, 1'b1);
    wait_cyc(hs + 14);
    chk("pf_buf1", 32'(wgt_buf_sel), 32'd1);
    chk("pf_grp1", 32'(grp_idx), 32'd1);
    wait_cyc(hs + 17);
    push_ev(K_DONE, 0, hs + 19);
    drive_done(1'b0, 1'b1);
    wait_cyc(hs + 20);
    chk("pf_busy", 32'(busy), 32'd0);
    chk("pf_pending", 32'(exp_q.size()), 32'd0);
    check_illegal("pf_ill_stride3", 16, 16, 8, 3);
`endif

    repeat (3) @(negedge clk);
    chk("final_pending", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
